// File: rtl/eusci_uart_pkg.sv
// eUSCI_A UART receive engine - shared constants.
//
// Holds the receive FSM state encoding, the default divisor width and the
// minimum effective bit period. Optional build macro EUSCI_RX_MAJORITY_EN
// raises the minimum period so three votes fit before the centre sample.

package eusci_uart_pkg;

   localparam int BR_WIDTH_DEF   = 16;

   localparam int MIN_PERIOD     = 2;
   localparam int MIN_PERIOD_MAJ = 6;

`ifdef EUSCI_RX_MAJORITY_EN
   localparam int MIN_PERIOD_EFF = MIN_PERIOD_MAJ;
`else
   localparam int MIN_PERIOD_EFF = MIN_PERIOD;
`endif

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP1  = 3'd4;
   localparam logic [2:0] ST_STOP2  = 3'd5;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/eusci_rx_bittimer.sv
// eUSCI_A UART receive bit timer.
//
// Down-counter that places a sample edge at the centre of every bit. On
// start the counter loads half the effective period and latches the period
// itself; afterwards each terminal count reloads period-1. UCBRx is only
// looked at on the start cycle, so divisor changes mid-frame have no effect.
//
// Ports:
//   BRCLK, RSTn   bit clock, asynchronous active-low reset
//   UCSWRST       synchronous clear
//   start         start-edge cycle: latch period, load half period
//   run           FSM is outside IDLE; counter runs
//   UCBRx         requested BRCLK cycles per bit
//   sample_edge   terminal count reached this cycle (bit centre)
//   vote_en[2:0]  (EUSCI_RX_MAJORITY_EN only) cnt==2, cnt==1, cnt==0

module eusci_rx_bittimer
   import eusci_uart_pkg::*;
#(
   parameter int BR_WIDTH = BR_WIDTH_DEF
) (
   input  logic                BRCLK,
   input  logic                RSTn,
   input  logic                UCSWRST,
   input  logic                start,
   input  logic                run,
   input  logic [BR_WIDTH-1:0] UCBRx,
   output logic                sample_edge
`ifdef EUSCI_RX_MAJORITY_EN
   ,
   output logic [2:0]          vote_en
`endif
);

   localparam logic [BR_WIDTH-1:0] MIN_P = BR_WIDTH'(MIN_PERIOD_EFF);
   localparam logic [BR_WIDTH-1:0] ONE   = BR_WIDTH'(1);

   logic [BR_WIDTH-1:0] period_in;
   logic [BR_WIDTH-1:0] period_q;
   logic [BR_WIDTH-1:0] cnt;
   logic                cnt_zero;

   assign period_in = (UCBRx < MIN_P) ? MIN_P : UCBRx;
   assign cnt_zero  = (cnt == '0);

   always_ff @(posedge BRCLK or negedge RSTn) begin
      if (!RSTn) begin
         cnt      <= '0;
         period_q <= '0;
      end else if (UCSWRST) begin
         cnt      <= '0;
         period_q <= '0;
      end else if (start) begin
         cnt      <= period_in >> 1;
         period_q <= period_in;
      end else if (run) begin
         cnt      <= cnt_zero ? (period_q - ONE) : (cnt - ONE);
      end else begin
         // parked at zero in IDLE so the next start loads from a known value
         cnt      <= '0;
      end
   end

   assign sample_edge = run & cnt_zero;

`ifdef EUSCI_RX_MAJORITY_EN
   assign vote_en = {run & (cnt == BR_WIDTH'(2)), run & (cnt == ONE), sample_edge};
`endif

endmodule

// File: rtl/eusci_uart_rx.sv
// eUSCI_A UART receive engine (top).
//
// Synchronizes UCRXD, detects the start edge from IDLE, samples each bit at
// its centre via eusci_rx_bittimer and deserializes 7/8-bit frames with
// optional parity and one or two stop bits. The finished character and its
// status flags are loaded on the final stop sample edge.
//
// Optional build macro: EUSCI_RX_MAJORITY_EN - each bit value is the 2-of-3
// vote of rxd_s at cnt = 2, 1, 0 and the minimum bit period becomes 6.
//
// Ports:
//   BRCLK, RSTn       bit clock, asynchronous active-low reset
//   UCSWRST           synchronous soft reset (holds everything at reset)
//   UCBRx             BRCLK cycles per bit (clamped to the minimum period)
//   UCPEN, UCPAR      parity enable, parity select (0 odd, 1 even)
//   UCMSB, UC7BIT     MSB-first order, 7-bit characters
//   UCSPB             two stop bits
//   UCRXD             asynchronous serial input, idle high
//   RXBUF_RD          one-cycle pulse: CPU read UCRXBUF
//   UCRXBUF           received character (bit 7 zero in 7-bit mode)
//   UCRXIFG           character available
//   UCFE, UCPE, UCOE  framing, parity, overrun error
//   UCRXERR           OR of the three error flags
//   UCBUSY            FSM outside IDLE
//
// state  | meaning
// IDLE   | waiting for a falling edge on rxd_s
// START  | timing to the start-bit centre, rejects false starts
// DATA   | capturing N data bits
// PARITY | checking the parity bit
// STOP1  | first stop bit; loads the buffer unless two stop bits
// STOP2  | second stop bit; loads the buffer

module eusci_uart_rx
   import eusci_uart_pkg::*;
#(
   parameter int BR_WIDTH    = BR_WIDTH_DEF,
   parameter int SYNC_STAGES = 2              // must be at least 2
) (
   input  logic                BRCLK,
   input  logic                RSTn,
   input  logic                UCSWRST,
   input  logic [BR_WIDTH-1:0] UCBRx,
   input  logic                UCPEN,
   input  logic                UCPAR,
   input  logic                UCMSB,
   input  logic                UC7BIT,
   input  logic                UCSPB,
   input  logic                UCRXD,
   input  logic                RXBUF_RD,
   output logic [7:0]          UCRXBUF,
   output logic                UCRXIFG,
   output logic                UCFE,
   output logic                UCPE,
   output logic                UCOE,
   output logic                UCRXERR,
   output logic                UCBUSY
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxd_s;
   logic                   rxd_prev;
   logic                   fall;

   logic [2:0] state;
   logic [2:0] state_nxt;

   logic       tmr_start;
   logic       load;
   logic       sample_edge;
   logic       samp;

   logic [7:0] data;
   logic [2:0] bitcnt;
   logic [2:0] last_idx;
   logic [2:0] bit_idx;
   logic       last_bit;
   logic       fe_pend;
   logic       pe_pend;
   logic       fe_final;
   logic       par_odd;

   // ---------------------------------------------------------------- sync
   always_ff @(posedge BRCLK or negedge RSTn) begin
      if (!RSTn) begin
         sync_q   <= '1;
         rxd_prev <= 1'b1;
      end else if (UCSWRST) begin
         sync_q   <= '1;
         rxd_prev <= 1'b1;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], UCRXD};
         rxd_prev <= rxd_s;
      end
   end

   assign rxd_s = sync_q[SYNC_STAGES-1];
   assign fall  = rxd_prev & ~rxd_s;

   // ---------------------------------------------------------- bit timer
`ifdef EUSCI_RX_MAJORITY_EN
   logic [2:0] vote_en;
   logic       vote2;
   logic       vote1;
`endif

   eusci_rx_bittimer #(
      .BR_WIDTH (BR_WIDTH)
   ) u_bittimer (
      .BRCLK       (BRCLK),
      .RSTn        (RSTn),
      .UCSWRST     (UCSWRST),
      .start       (tmr_start),
      .run         (UCBUSY),
      .UCBRx       (UCBRx),
      .sample_edge (sample_edge)
`ifdef EUSCI_RX_MAJORITY_EN
      ,
      .vote_en     (vote_en)
`endif
   );

`ifdef EUSCI_RX_MAJORITY_EN
   always_ff @(posedge BRCLK or negedge RSTn) begin
      if (!RSTn) begin
         vote2 <= 1'b1;
         vote1 <= 1'b1;
      end else if (UCSWRST) begin
         vote2 <= 1'b1;
         vote1 <= 1'b1;
      end else begin
         if (vote_en[2]) vote2 <= rxd_s;
         if (vote_en[1]) vote1 <= rxd_s;
      end
   end

   // third vote is rxd_s itself on the sample edge (cnt==0)
   assign samp = majority3(vote2, vote1, rxd_s);
`else
   assign samp = rxd_s;
`endif

   // ---------------------------------------------------------------- FSM
   assign last_idx = UC7BIT ? 3'd6 : 3'd7;
   assign last_bit = (bitcnt == last_idx);

   always_ff @(posedge BRCLK or negedge RSTn) begin
      if (!RSTn) begin
         state <= ST_IDLE;
      end else if (UCSWRST) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (fall) state_nxt = ST_START;
         end
         ST_START: begin
            if (sample_edge) state_nxt = samp ? ST_IDLE : ST_DATA;
         end
         ST_DATA: begin
            if (sample_edge && last_bit) state_nxt = UCPEN ? ST_PARITY : ST_STOP1;
         end
         ST_PARITY: begin
            if (sample_edge) state_nxt = ST_STOP1;
         end
         ST_STOP1: begin
            if (sample_edge) state_nxt = UCSPB ? ST_STOP2 : ST_IDLE;
         end
         ST_STOP2: begin
            if (sample_edge) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      UCBUSY    = (state != ST_IDLE);
      tmr_start = (state == ST_IDLE) & fall;
      load      = sample_edge &
                  (((state == ST_STOP1) & ~UCSPB) | (state == ST_STOP2));
   end

   // ----------------------------------------------------------- datapath
   assign bit_idx  = UCMSB ? (last_idx - bitcnt) : bitcnt;
   assign par_odd  = ^{data, samp};
   // the final stop sample must be folded in here because the load uses it
   // on the same edge
   assign fe_final = ~samp | ((state == ST_STOP2) & fe_pend);

   always_ff @(posedge BRCLK or negedge RSTn) begin
      if (!RSTn) begin
         data    <= '0;
         bitcnt  <= '0;
         fe_pend <= 1'b0;
         pe_pend <= 1'b0;
         UCRXBUF <= '0;
         UCRXIFG <= 1'b0;
         UCFE    <= 1'b0;
         UCPE    <= 1'b0;
         UCOE    <= 1'b0;
      end else if (UCSWRST) begin
         data    <= '0;
         bitcnt  <= '0;
         fe_pend <= 1'b0;
         pe_pend <= 1'b0;
         UCRXBUF <= '0;
         UCRXIFG <= 1'b0;
         UCFE    <= 1'b0;
         UCPE    <= 1'b0;
         UCOE    <= 1'b0;
      end else begin
         if (tmr_start) begin
            data    <= '0;
            bitcnt  <= '0;
            fe_pend <= 1'b0;
            pe_pend <= 1'b0;
         end

         if (sample_edge) begin
            case (state)
               ST_DATA: begin
                  data[bit_idx] <= samp;
                  bitcnt        <= bitcnt + 3'd1;
               end
               ST_PARITY: pe_pend <= UCPAR ? par_odd : ~par_odd;
               ST_STOP1,
               ST_STOP2:  fe_pend <= fe_final;
               default: ;
            endcase
         end

         // a load beats a simultaneous read; the read then only suppresses OE
         if (load) begin
            UCRXBUF <= data;
            UCRXIFG <= 1'b1;
            UCFE    <= fe_final;
            UCPE    <= pe_pend;
            UCOE    <= UCRXIFG & ~RXBUF_RD;
         end else if (RXBUF_RD) begin
            UCRXIFG <= 1'b0;
            UCFE    <= 1'b0;
            UCPE    <= 1'b0;
            UCOE    <= 1'b0;
         end
      end
   end

   assign UCRXERR = UCFE | UCPE | UCOE;

endmodule

// File: tb/tb_eusci_uart_rx.sv
// Self-checking bench for eusci_uart_rx (default build, majority voting off).

module tb_eusci_uart_rx;

   logic        BRCLK = 1'b0;
   logic        RSTn = 1'b0;
   logic        UCSWRST = 1'b0;
   logic [15:0] UCBRx = 16'd16;
   logic        UCPEN = 1'b0;
   logic        UCPAR = 1'b0;
   logic        UCMSB = 1'b0;
   logic        UC7BIT = 1'b0;
   logic        UCSPB = 1'b0;
   logic        UCRXD = 1'b1;
   logic        RXBUF_RD = 1'b0;
   logic [7:0]  UCRXBUF;
   logic        UCRXIFG;
   logic        UCFE;
   logic        UCPE;
   logic        UCOE;
   logic        UCRXERR;
   logic        UCBUSY;

   int n_chk = 0;
   int n_pass = 0;

   always #5 BRCLK = ~BRCLK;

   eusci_uart_rx #(
      .BR_WIDTH    (16),
      .SYNC_STAGES (2)
   ) dut (
      .BRCLK    (BRCLK),
      .RSTn     (RSTn),
      .UCSWRST  (UCSWRST),
      .UCBRx    (UCBRx),
      .UCPEN    (UCPEN),
      .UCPAR    (UCPAR),
      .UCMSB    (UCMSB),
      .UC7BIT   (UC7BIT),
      .UCSPB    (UCSPB),
      .UCRXD    (UCRXD),
      .RXBUF_RD (RXBUF_RD),
      .UCRXBUF  (UCRXBUF),
      .UCRXIFG  (UCRXIFG),
      .UCFE     (UCFE),
      .UCPE     (UCPE),
      .UCOE     (UCOE),
      .UCRXERR  (UCRXERR),
      .UCBUSY   (UCBUSY)
   );

   typedef struct {
      logic [15:0] ubr;
      int          ext;     // extra start-bit cycles (needed only at P=2)
      logic        pen;
      logic        par;
      logic        msb;
      logic        b7;
      logic        spb;
      logic [7:0]  d;
      logic        pbit;
      logic        stop1;
      logic        stop2;
      logic [7:0]  e_buf;
      logic        e_fe;
      logic        e_pe;
   } vec_t;

   vec_t vecs[11];

   function automatic vec_t mk(input logic [15:0] ubr, input int ext,
                               input logic pen, input logic par, input logic msb,
                               input logic b7, input logic spb, input logic [7:0] d,
                               input logic pbit, input logic stop1, input logic stop2,
                               input logic [7:0] e_buf, input logic e_fe, input logic e_pe);
      vec_t v;
      v.ubr = ubr; v.ext = ext; v.pen = pen; v.par = par; v.msb = msb;
      v.b7 = b7; v.spb = spb; v.d = d; v.pbit = pbit; v.stop1 = stop1;
      v.stop2 = stop2; v.e_buf = e_buf; v.e_fe = e_fe; v.e_pe = e_pe;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
   endtask

   // Called on a negedge; drives one complete frame then 4 idle cycles.
   task automatic send(input vec_t v);
      int p;
      int n;
      p = (v.ubr < 16'd2) ? 2 : int'(v.ubr);
      n = v.b7 ? 7 : 8;
      UCBRx = v.ubr; UCPEN = v.pen; UCPAR = v.par; UCMSB = v.msb;
      UC7BIT = v.b7; UCSPB = v.spb;
      UCRXD = 1'b0;
      repeat (p + v.ext) @(negedge BRCLK);
      for (int i = 0; i < n; i++) begin
         UCRXD = v.d[v.msb ? (n - 1 - i) : i];
         repeat (p) @(negedge BRCLK);
      end
      if (v.pen) begin
         UCRXD = v.pbit;
         repeat (p) @(negedge BRCLK);
      end
      UCRXD = v.stop1;
      repeat (p) @(negedge BRCLK);
      if (v.spb) begin
         UCRXD = v.stop2;
         repeat (p) @(negedge BRCLK);
      end
      UCRXD = 1'b1;
      repeat (4) @(negedge BRCLK);
   endtask

   task automatic pulse_rd();
      @(negedge BRCLK);
      RXBUF_RD = 1'b1;
      @(negedge BRCLK);
      RXBUF_RD = 1'b0;
   endtask

   task automatic wait_idle();
      int c;
      c = 0;
      while (UCBUSY && c < 1000) begin
         @(negedge BRCLK);
         c++;
      end
      chk("idle_timeout", UCBUSY, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int         cyc;
      logic       busy_seen;
      logic [7:0] buf_before;
      vec_t       v;

      //        ubr ext pen par msb b7 spb  data  pb s1 s2  e_buf fe pe
      vecs[0]  = mk(16, 0, 0, 0, 0, 0, 0, 8'hA5, 0, 1, 1, 8'hA5, 0, 0);
      vecs[1]  = mk(16, 0, 1, 1, 0, 0, 0, 8'h03, 1, 1, 1, 8'h03, 0, 1);
      vecs[2]  = mk(16, 0, 1, 1, 0, 0, 0, 8'h03, 0, 1, 1, 8'h03, 0, 0);
      vecs[3]  = mk( 8, 0, 0, 0, 0, 0, 0, 8'h5A, 0, 0, 1, 8'h5A, 1, 0);
      vecs[4]  = mk(12, 0, 1, 0, 0, 0, 0, 8'h07, 0, 1, 1, 8'h07, 0, 0);
      vecs[5]  = mk(12, 0, 1, 0, 0, 0, 0, 8'h07, 1, 1, 1, 8'h07, 0, 1);
      vecs[6]  = mk(10, 0, 0, 0, 0, 1, 0, 8'hC3, 0, 1, 1, 8'h43, 0, 0);
      vecs[7]  = mk(12, 0, 0, 0, 1, 0, 0, 8'h1E, 0, 1, 1, 8'h1E, 0, 0);
      vecs[8]  = mk(16, 0, 0, 0, 0, 0, 1, 8'h3C, 0, 1, 0, 8'h3C, 1, 0);
      vecs[9]  = mk( 1, 1, 0, 0, 0, 0, 0, 8'h96, 0, 1, 1, 8'h96, 0, 0);
      vecs[10] = mk( 8, 0, 1, 1, 1, 1, 1, 8'h4D, 0, 1, 1, 8'h4D, 0, 0);

      // reset state
      repeat (3) @(negedge BRCLK);
      chk("rst_rxbuf", UCRXBUF, 8'h00);
      chk("rst_ifg", UCRXIFG, 1'b0);
      chk("rst_err", UCRXERR, 1'b0);
      chk("rst_busy", UCBUSY, 1'b0);
      RSTn = 1'b1;
      repeat (3) @(negedge BRCLK);

      // 8N1 0xA5 at UCBRx=16: start edge seen on posedge 3 (two sync flops
      // plus edge detect), stop sample 9+16*9 edges later -> posedge 156
      cyc = 0;
      fork
         send(vecs[0]);
         begin
            while (!UCRXIFG && cyc < 400) begin
               @(posedge BRCLK);
               #1;
               cyc++;
            end
         end
      join
      chk("lat_cycles", cyc, 156);
      chk("lat_rxbuf", UCRXBUF, 8'hA5);
      chk("lat_err", UCRXERR, 1'b0);
      wait_idle();

      // table-driven frames, each from a cleared receiver
      for (int i = 0; i < 11; i++) begin
         pulse_rd();
         send(vecs[i]);
         wait_idle();
         chk($sformatf("v%0d_rxbuf", i), UCRXBUF, vecs[i].e_buf);
         chk($sformatf("v%0d_ifg", i), UCRXIFG, 1'b1);
         chk($sformatf("v%0d_fe", i), UCFE, vecs[i].e_fe);
         chk($sformatf("v%0d_pe", i), UCPE, vecs[i].e_pe);
         chk($sformatf("v%0d_oe", i), UCOE, 1'b0);
         chk($sformatf("v%0d_err", i), UCRXERR, vecs[i].e_fe | vecs[i].e_pe);
         pulse_rd();
         chk($sformatf("v%0d_rd_ifg", i), UCRXIFG, 1'b0);
         chk($sformatf("v%0d_rd_err", i), UCRXERR, 1'b0);
         chk($sformatf("v%0d_rd_buf", i), UCRXBUF, vecs[i].e_buf);
      end

      // overrun: two frames without a read
      pulse_rd();
      send(mk(16, 0, 0, 0, 0, 0, 0, 8'h11, 0, 1, 1, 8'h11, 0, 0));
      wait_idle();
      send(mk(16, 0, 0, 0, 0, 0, 0, 8'h22, 0, 1, 1, 8'h22, 0, 0));
      wait_idle();
      chk("ovr_rxbuf", UCRXBUF, 8'h22);
      chk("ovr_oe", UCOE, 1'b1);
      chk("ovr_ifg", UCRXIFG, 1'b1);
      chk("ovr_err", UCRXERR, 1'b1);

      // read pulse on the exact load edge (posedge 156) of the second frame
      pulse_rd();
      send(mk(16, 0, 0, 0, 0, 0, 0, 8'h11, 0, 1, 1, 8'h11, 0, 0));
      wait_idle();
      fork
         send(mk(16, 0, 0, 0, 0, 0, 0, 8'h22, 0, 1, 1, 8'h22, 0, 0));
         begin
            repeat (155) @(posedge BRCLK);
            @(negedge BRCLK);
            RXBUF_RD = 1'b1;
            @(negedge BRCLK);
            RXBUF_RD = 1'b0;
         end
      join
      wait_idle();
      chk("rdload_oe", UCOE, 1'b0);
      chk("rdload_ifg", UCRXIFG, 1'b1);
      chk("rdload_rxbuf", UCRXBUF, 8'h22);

      // 3-cycle glitch: false start, no flag changes
      pulse_rd();
      buf_before = UCRXBUF;
      busy_seen = 1'b0;
      UCBRx = 16'd16;
      UCRXD = 1'b0;
      fork
         begin
            repeat (3) @(negedge BRCLK);
            UCRXD = 1'b1;
         end
         begin
            repeat (40) begin
               @(negedge BRCLK);
               if (UCBUSY) busy_seen = 1'b1;
            end
         end
      join
      chk("glitch_busy_seen", busy_seen, 1'b1);
      chk("glitch_busy_end", UCBUSY, 1'b0);
      chk("glitch_ifg", UCRXIFG, 1'b0);
      chk("glitch_err", UCRXERR, 1'b0);
      chk("glitch_rxbuf", UCRXBUF, buf_before);

      // soft reset during data bit 3 of a 7-bit MSB-first 2-stop frame
      v = mk(16, 0, 0, 0, 1, 1, 1, 8'h4D, 0, 1, 1, 8'h4D, 0, 0);
      fork
         send(v);
         begin
            repeat (72) @(negedge BRCLK);
            chk("swrst_busy_before", UCBUSY, 1'b1);
            UCSWRST = 1'b1;
         end
      join
      repeat (2) @(negedge BRCLK);
      chk("swrst_busy", UCBUSY, 1'b0);
      chk("swrst_ifg", UCRXIFG, 1'b0);
      chk("swrst_rxbuf", UCRXBUF, 8'h00);
      chk("swrst_err", UCRXERR, 1'b0);
      UCSWRST = 1'b0;
      repeat (4) @(negedge BRCLK);
      send(v);
      wait_idle();
      chk("resend_rxbuf", UCRXBUF, 8'h4D);
      chk("resend_ifg", UCRXIFG, 1'b1);
      chk("resend_err", UCRXERR, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/eusci_uart_rx.md
Name: eusci_uart_rx

Overview:
- Receive engine for the eUSCI_A UART.
- Counterpart to the baud prescaler on the transmit-timing side: recovers bit timing from a start-bit edge on UCRXD and samples each bit at its centre.
- Deserializes 7/8-bit frames with optional parity and 1/2 stop bits, then presents UCRXBUF and status flags to the register file.
- Runs entirely in the BRCLK domain.

Parameters:
- BR_WIDTH, 16, width of the bit-period divisor UCBRx.
- SYNC_STAGES, 2, number of flops in the UCRXD synchronizer (minimum 2).

Ports:
- BRCLK  in  1  bit clock; all state changes on rising edge.
- RSTn  in  1  asynchronous active-low reset.
- UCSWRST  in  1  synchronous soft reset; while high, all state and outputs are held at reset values.
- UCBRx  in  BR_WIDTH  BRCLK cycles per bit.
- UCPEN  in  1  parity enable.
- UCPAR  in  1  parity select: 0 = odd, 1 = even.
- UCMSB  in  1  1 = MSB first.
- UC7BIT  in  1  1 = 7 data bits.
- UCSPB  in  1  1 = two stop bits.
- UCRXD  in  1  serial input, asynchronous, idle high.
- RXBUF_RD  in  1  one-cycle pulse: the CPU read UCRXBUF.
- UCRXBUF  out  8  received character; bit 7 is 0 in 7-bit mode.
- UCRXIFG  out  1  character available.
- UCFE  out  1  framing error.
- UCPE  out  1  parity error.
- UCOE  out  1  overrun error.
- UCRXERR  out  1  UCFE | UCPE | UCOE.
- UCBUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (RSTn low or UCSWRST high):
  - All outputs 0; state IDLE; counter 0.
  - Synchronizer flops preset to 1.
- Effective bit period: P = max(UCBRx, 2). UCBRx is sampled only on the start-edge cycle; changes mid-frame are ignored.
- rxd_s is the synchronized UCRXD. A falling edge on rxd_s (previous 1, current 0) is detected only in IDLE.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- Bit timer:
  - On entry to START, load cnt = P>>1.
  - cnt decrements every BRCLK.
  - An edge where cnt==0 is a "sample edge"; on that edge cnt reloads to P-1.
- State transitions (all on sample edges unless noted):
  - IDLE→START: on falling edge of rxd_s.
  - START: sample 1 = false start, go to IDLE with no flag change. Sample 0 → DATA, with bitcnt = 0.
  - DATA: capture the bit.
    - LSB first: data[bitcnt].
    - MSB first: data[N-1-bitcnt], where N = 7 or 8.
    - After bit N-1, go to PARITY if UCPEN, else STOP1.
  - PARITY: pe_pend = (ones(data) + sample) is odd when UCPAR=1, or even when UCPAR=0. Then → STOP1.
  - STOP1: fe_pend = (sample==0). Go to STOP2 if UCSPB, else load.
  - STOP2: fe_pend |= (sample==0), then load.
- Load (same edge as the final stop sample), then return to IDLE:
  - UCRXBUF <= data.
  - UCRXIFG <= 1.
  - UCFE <= fe_pend; UCPE <= pe_pend.
  - UCOE <= 1 if UCRXIFG was already 1 and RXBUF_RD is 0 this cycle.
- A load still occurs on a framing error, and the character is stored.
- Outputs are visible one clock after the final stop sample edge.
- RXBUF_RD (no load that cycle): clears UCRXIFG, UCFE, UCPE, UCOE.
- RXBUF_RD on the same cycle as a load: load wins. UCRXIFG stays 1, flags take the new frame's values, and UCOE = 0.
- A falling edge during STOP states is ignored. The next start edge is detected from IDLE on the cycle after the load, which allows back-to-back frames.
- Asserting UCSWRST mid-frame aborts the frame. No flags are set and UCRXBUF keeps its reset value (0).

Optional Feature:
- Macro: EUSCI_RX_MAJORITY_EN.
- Defined:
  - P = max(UCBRx, 6).
  - Each sample value is the 2-of-3 majority of rxd_s taken at cnt = 2, 1, 0.
  - The START false-start check uses the voted value.
- Undefined: single sample at cnt==0; P = max(UCBRx, 2).

Decomposition:
- Package eusci_uart_pkg holds:
  - the state encoding localparams (IDLE=0 … STOP2=5);
  - BR_WIDTH default;
  - the min-period constants (2, and 6 for majority).
- One sub-module, eusci_rx_bittimer, holds the load/decrement counter. It outputs sample_edge and, under EUSCI_RX_MAJORITY_EN, vote_en[2:0].
- The FSM, shift logic and flag logic stay in eusci_uart_rx.

Test Plan:
- 8N1, LSB first, UCBRx=16, send 0xA5: UCRXBUF=0xA5 and UCRXIFG=1 one clock after the stop sample (~152 BRCLK after the start edge); UCRXERR=0.
- 8E1 (UCPEN=1, UCPAR=1), send 0x03 with parity bit 1: UCPE=1, UCRXBUF=0x03. Resend with the correct parity bit 0 after RXBUF_RD: UCPE=0.
- Stop bit driven 0, UCBRx=8, send 0x5A: UCFE=1, UCRXIFG=1. Pulse RXBUF_RD: all flags go to 0.
- Two frames 0x11 then 0x22 with no RXBUF_RD: UCRXBUF=0x22, UCOE=1. Repeat with RXBUF_RD pulsed on the exact load cycle of the second frame: UCOE=0, UCRXIFG=1.
- Glitch: UCRXD low for 3 BRCLK with UCBRx=16: returns to IDLE, UCBUSY pulses, no flag changes.
- 7-bit, MSB first, two stop bits, send 0x4D, assert UCSWRST during data bit 3, release, then resend 0x4D: first frame discarded with no flags; second frame gives UCRXBUF=0x4D.
